// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle-latency ROM and hands {pc, pc+inc, instr} to decode.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
//
// state  | meaning
// S_BOOT | first cycle after reset release, unconditionally issues PC_RESET
// S_RUN  | issuing one fetch per cycle while the skid has room for it
// S_HOLD | skid plus in-flight response would fill the skid; ROM address frozen
module fetch_unit #(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] PC_RESET   = 32'h0040_0000,
    parameter int          PC_INC     = 4,
    parameter int          SKID_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              redirect_in,
    input  logic [ADDR_W-1:0] redirect_target_in,
    output logic [ADDR_W-1:0] rom_addr_out,
    input  logic [31:0]       rom_data_in,
    output logic              valid_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_next_out,
    output logic [31:0]       instr_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched_out,
    output logic [31:0]       perf_flushed_out,
    output logic [31:0]       perf_stall_out
`endif
);

    localparam int PTR_W = (SKID_DEPTH > 2) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET);
    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] ALIGN    = ~ADDR_W'(3);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HOLD} stateType;

    stateType          state, stateNext;
    logic [ADDR_W-1:0] fetchPc, inflightPc;
    logic              inflight, issue;
    logic [ADDR_W-1:0] skidPc    [SKID_DEPTH];
    logic [31:0]       skidInstr [SKID_DEPTH];
    logic [PTR_W-1:0]  rdPtr, wrPtr;
    logic [CNT_W-1:0]  count;
    logic              consume, outFree, skidEmpty, loadFromSkid, loadFromResp;
    logic              push, pop, room;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rom_addr_out = fetchPc;
    assign consume      = valid_out & ~stall_in;
    assign outFree      = ~valid_out | consume;
    assign skidEmpty    = (count == '0);
    assign loadFromSkid = outFree & ~skidEmpty;
    assign loadFromResp = outFree & skidEmpty & inflight;
    // Any response not taken straight into the output goes behind older skid entries.
    assign push         = inflight & ~loadFromResp;
    assign pop          = loadFromSkid;
    assign room         = (int'(count) + int'(inflight)) < SKID_DEPTH;

    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        case (state)
            S_BOOT: begin
                issue     = 1'b1;
                stateNext = S_RUN;
            end
            S_RUN: begin
                if (room) issue = 1'b1;
                else      stateNext = S_HOLD;
            end
            S_HOLD: begin
                if (room) stateNext = S_RUN;
            end
            default: stateNext = S_BOOT;
        endcase
        if (redirect_in) begin
            issue     = 1'b0;
            stateNext = S_RUN;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_BOOT;
            fetchPc    <= RESET_PC;
            inflight   <= 1'b0;
            inflightPc <= '0;
        end else begin
            state <= stateNext;
            if (redirect_in) begin
                fetchPc  <= redirect_target_in & ALIGN;
                inflight <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    fetchPc    <= fetchPc + INC;
                    inflightPc <= fetchPc;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            skidPc[wrPtr]    <= inflightPc;
            skidInstr[wrPtr] <= rom_data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_out   <= 1'b0;
            pc_out      <= '0;
            pc_next_out <= '0;
            instr_out   <= '0;
            count       <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
        end else if (redirect_in) begin
            valid_out <= 1'b0;
            count     <= '0;
            rdPtr     <= '0;
            wrPtr     <= '0;
        end else begin
            if (loadFromSkid) begin
                valid_out   <= 1'b1;
                pc_out      <= skidPc[rdPtr];
                pc_next_out <= skidPc[rdPtr] + INC;
                instr_out   <= skidInstr[rdPtr];
            end else if (loadFromResp) begin
                valid_out   <= 1'b1;
                pc_out      <= inflightPc;
                pc_next_out <= inflightPc + INC;
                instr_out   <= rom_data_in;
            end else if (outFree) begin
                valid_out <= 1'b0;
            end
            if (push) wrPtr <= ptrInc(wrPtr);
            if (pop)  rdPtr <= ptrInc(rdPtr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched_out <= '0;
            perf_flushed_out <= '0;
            perf_stall_out   <= '0;
        end else begin
            if (consume) perf_fetched_out <= perf_fetched_out + 32'd1;
            if (redirect_in)
                perf_flushed_out <= perf_flushed_out + 32'(valid_out) + 32'(count) + 32'(inflight);
            if (valid_out & stall_in) perf_stall_out <= perf_stall_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a program-order model (expected next PC) checked every cycle, plus directed literal checks.
module tb_fetch_unit;
    localparam logic [31:0] PC_RST = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset, stall_in, redirect_in;
    logic [31:0] redirect_target_in, rom_addr_out, rom_data_in, pc_out, pc_next_out, instr_out;
    logic        valid_out;

    logic        stall16 = 1'b0, redir16 = 1'b0;
    logic [15:0] tgt16 = 16'h0, romAddr16, pc16, pcNext16;
    logic [31:0] romData16, instr16;
    logic        valid16;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetched, perfFlushed, perfStall, perfF16, perfFl16, perfSt16;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock(clock), .reset(reset), .stall_in(stall_in), .redirect_in(redirect_in),
        .redirect_target_in(redirect_target_in), .rom_addr_out(rom_addr_out),
        .rom_data_in(rom_data_in), .valid_out(valid_out), .pc_out(pc_out),
        .pc_next_out(pc_next_out), .instr_out(instr_out)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched_out(perfFetched), .perf_flushed_out(perfFlushed), .perf_stall_out(perfStall)
`endif
    );

    fetch_unit #(.ADDR_W(16), .PC_RESET(32'h0000_FFF8)) dut16 (
        .clock(clock), .reset(reset), .stall_in(stall16), .redirect_in(redir16),
        .redirect_target_in(tgt16), .rom_addr_out(romAddr16),
        .rom_data_in(romData16), .valid_out(valid16), .pc_out(pc16),
        .pc_next_out(pcNext16), .instr_out(instr16)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched_out(perfF16), .perf_flushed_out(perfFl16), .perf_stall_out(perfSt16)
`endif
    );

    function automatic logic [31:0] romFunc(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous ROMs: data for the address presented in the previous cycle.
    always @(posedge clock) begin
        rom_data_in <= romFunc(rom_addr_out);
        romData16   <= romFunc({16'h0, romAddr16});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the only legal instruction on the output is the next one in program order.
    logic [31:0] expPc, prevPc, prevInstr;
    logic        prevHold;
    int          sinceRel = 100, sinceRedir = 0, gapCnt = 0;
    logic        redirPend = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_valid", {31'b0, valid_out}, 32'd0);
            chk("rst_pc", pc_out, 32'd0);
            expPc     = PC_RST;
            sinceRel  = 0;
            redirPend = 1'b0;
            prevHold  = 1'b0;
            gapCnt    = 0;
        end else begin
            if (sinceRel <= 2)
                chk("boot_latency", {31'b0, valid_out}, (sinceRel == 2) ? 32'd1 : 32'd0);
            if (sinceRel < 100) sinceRel++;
            if (redirPend) begin
                sinceRedir++;
                chk("redir_latency", {31'b0, valid_out}, (sinceRedir == 3) ? 32'd1 : 32'd0);
                if (sinceRedir == 3) redirPend = 1'b0;
            end
            if (prevHold) begin
                chk("hold_valid", {31'b0, valid_out}, 32'd1);
                chk("hold_pc", pc_out, prevPc);
                chk("hold_instr", instr_out, prevInstr);
            end
            if (valid_out) begin
                chk("order_pc", pc_out, expPc);
                chk("order_pc_next", pc_next_out, expPc + 32'd4);
                chk("order_instr", instr_out, romFunc(expPc));
                gapCnt = 0;
                if (!stall_in) expPc = expPc + 32'd4;
            end else begin
                gapCnt++;
            end
            prevHold  = valid_out & stall_in & ~redirect_in;
            prevPc    = pc_out;
            prevInstr = instr_out;
            if (redirect_in) begin
                expPc      = redirect_target_in & ~32'd3;
                redirPend  = 1'b1;
                sinceRedir = 0;
                gapCnt     = 0;
            end
            if (gapCnt > 8) begin
                chk("liveness", 32'd0, 32'd1);
                gapCnt = 0;
            end
        end
    end

    // 16-bit instance: the first four fetched addresses wrap through zero.
    logic [15:0] exp16 [4] = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
    logic [15:0] e16, en16;
    int          n16 = 0;

    always @(negedge clock) begin
        if (!reset) begin
            n16 = 0;
        end else if (valid16 && n16 < 4) begin
            e16  = exp16[n16];
            en16 = e16 + 16'd4;
            chk("wrap16_pc", {16'h0, pc16}, {16'h0, e16});
            chk("wrap16_pc_next", {16'h0, pcNext16}, {16'h0, en16});
            chk("wrap16_instr", instr16, romFunc({16'h0, e16}));
            n16++;
        end
    end

    task automatic redirTo(input logic [31:0] tgt, input logic withStall);
        @(posedge clock); #1;
        redirect_in = 1'b1; redirect_target_in = tgt; stall_in = withStall;
        @(posedge clock); #1;
        redirect_in = 1'b0; stall_in = 1'b0;
        @(negedge clock); chk("redir_r1_valid", {31'b0, valid_out}, 32'd0);
        @(negedge clock); chk("redir_r2_valid", {31'b0, valid_out}, 32'd0);
        @(negedge clock);
        chk("redir_r3_valid", {31'b0, valid_out}, 32'd1);
        chk("redir_r3_pc", pc_out, tgt & 32'hFFFF_FFFC);
        chk("redir_r3_instr", instr_out, romFunc(tgt & 32'hFFFF_FFFC));
    endtask

    initial begin
        reset = 1'b0; stall_in = 1'b0; redirect_in = 1'b0; redirect_target_in = 32'h0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        chk("boot_pc", pc_out, 32'h0040_0000);
        chk("boot_pc_next", pc_next_out, 32'h0040_0004);
        @(negedge clock);
        chk("seq_pc1", pc_out, 32'h0040_0004);

        // Stall three cycles while 0x00400008 is on the output.
        @(posedge clock); #1 stall_in = 1'b1;
        @(negedge clock); chk("stall_pc", pc_out, 32'h0040_0008);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("stall_rom_frozen", rom_addr_out, 32'h0040_0014);
        chk("stall_pc_held", pc_out, 32'h0040_0008);
        @(posedge clock); #1 stall_in = 1'b0;
        @(negedge clock); chk("release_pc0", pc_out, 32'h0040_0008);
        @(negedge clock); chk("release_pc1", pc_out, 32'h0040_000C);
        @(negedge clock); chk("release_pc2", pc_out, 32'h0040_0010);

        repeat (6) @(posedge clock);
        redirTo(32'h0040_0103, 1'b0);

        // Fill the skid with a stall, then redirect while still stalled.
        @(posedge clock); #1 stall_in = 1'b1;
        @(posedge clock);
        redirTo(32'h0040_0200, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            stall_in           = ($urandom_range(0, 9) < 3);
            redirect_in        = ($urandom_range(0, 39) == 0);
            redirect_target_in = $urandom;
        end
        @(posedge clock); #1;
        stall_in = 1'b0; redirect_in = 1'b0;
        repeat (10) @(posedge clock);

        // Asynchronous reset in the middle of a stall with a full skid.
        #1 stall_in = 1'b1;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", {31'b0, valid_out}, 32'd0);
        chk("async_pc", pc_out, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched_rst", perfFetched, 32'd0);
        chk("perf_flushed_rst", perfFlushed, 32'd0);
        chk("perf_stall_rst", perfStall, 32'd0);
`endif
        stall_in = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        chk("refetch_pc", pc_out, 32'h0040_0000);
        repeat (20) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage for the 4-stage pipelined processor; replaces the free-running PC register and adder of the single-cycle core.
- Owns the PC and drives the synchronous instruction ROM, which has 1-cycle read latency.
- Hands {pc, pc+inc, instruction} to decode through a valid/stall handshake.
- Absorbs the in-flight ROM response in a skid buffer on stall, and flushes everything on a branch/jump redirect.

Parameters:
- ADDR_W, 32: PC and ROM address width.
- PC_RESET, 32'h0040_0000: fetch address after reset (truncated to ADDR_W).
- PC_INC, 4: byte increment per sequential fetch.
- SKID_DEPTH, 2: skid FIFO entries; minimum 2.

Ports:
- clock, in, 1: single clock; all state on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- stall_in, in, 1: decode cannot accept this cycle.
- redirect_in, in, 1: branch/jump taken; flush and refetch.
- redirect_target_in, in, ADDR_W: new fetch address.
- rom_addr_out, out, ADDR_W: ROM address (driven from fetch_pc register).
- rom_data_in, in, 32: ROM data for the address presented the previous cycle.
- valid_out, out, 1: pc_out/instr_out/pc_next_out hold a live instruction.
- pc_out, out, ADDR_W: address of instr_out.
- pc_next_out, out, ADDR_W: pc_out + PC_INC, modulo 2^ADDR_W.
- instr_out, out, 32: fetched instruction.

Behaviour:
- Reset (reset=0, async):
  - fetch_pc=PC_RESET; inflight=0; skid empty; valid_out=0; pc_out=0; pc_next_out=0; instr_out=0; state=S_BOOT.
- FSM:
  - S_BOOT: first cycle after release. Issue PC_RESET. -> S_RUN.
  - S_RUN: issue when count+inflight < SKID_DEPTH; otherwise -> S_HOLD.
  - S_HOLD: no issue; rom_addr_out holds. -> S_RUN when count+inflight < SKID_DEPTH.
  - Redirect from any state -> S_RUN.
- Issue:
  - rom_addr_out=fetch_pc. On issue, at the edge: fetch_pc += PC_INC (wraps at 2^ADDR_W), inflight=1, inflight_pc=fetch_pc.
  - No issue: inflight=0.
- Response: when inflight=1, rom_data_in is valid this cycle and is tagged with inflight_pc.
- Output register:
  - Consume = valid_out & !stall_in.
  - If output is empty or consumed, load next from the skid head if non-empty, else from the arriving response, else valid_out=0.
  - Arriving responses go to the skid tail whenever the output is not free or the skid is non-empty; program order is preserved.
  - Simultaneous skid pop and push in the same cycle is allowed.
- Stall: output registers hold exactly. No instruction is dropped or duplicated.
- Redirect (priority over stall and issue), at the edge:
  - valid_out=0; skid cleared; inflight killed (the current rom_data_in is discarded).
  - fetch_pc = redirect_target_in with bits[1:0] forced to 0.
  - Target is presented on rom_addr_out next cycle; valid_out with the target 3 cycles after the redirect cycle.
- Latency:
  - Reset release at cycle 0: PC_RESET instruction is valid_out in cycle 2.
  - Steady state: 1 instruction/cycle with no stall.
- Skid overflow is impossible by the issue rule. Back-to-back redirects: the last one wins.
- Async reset mid-stream: all state cleared immediately; fetch restarts from PC_RESET.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined adds three 32-bit output ports, each wrapping, each cleared by reset:
  - perf_fetched_out: counts consumes.
  - perf_flushed_out: adds the number of live entries killed per redirect (valid_out + count + inflight).
  - perf_stall_out: counts cycles with valid_out & stall_in.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset release, ROM returns addr-derived data, stall_in=0 -> valid_out rises in cycle 2 with pc_out=0x00400000; pc_out then increments by 4 every cycle; pc_next_out=pc_out+4.
- Steady stream, stall_in high for 3 cycles at pc_out=0x00400008 -> outputs held 3 cycles, rom_addr_out frozen once skid holds 2 entries; after release, sequence 0x0040000C, 0x00400010, ... with no gap or repeat.
- redirect_in at cycle R with target 0x00400103 -> valid_out=0 in R+1 and R+2; in R+3 pc_out=0x00400100 with its instruction; stale responses never appear.
- redirect_in and stall_in asserted together while the skid holds 2 entries -> skid flushed; the target instruction still appears at R+3 if stall drops.
- ADDR_W=16, PC_RESET=16'hFFF8 -> pc_out sequence FFF8, FFFC, 0000, 0004.
- Async reset asserted mid-stall with a full skid -> valid_out=0 immediately; after release, 0x00400000 is re-fetched. With FETCH_PERF_CNT_EN, counters read 0.
